hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the RV32I 5-stage core (IF/ID/EX/MEM/WB).
//  - Schedules load-use stalls, taken-branch/jump flushes and data-memory wait freezes.
//  - Generates the EX-stage operand forwarding selects.
//  - Keeps saturating stall/flush event counters for performance debug.
//  - Sits beside the ID/EX control path; drives stall/flush enables of every pipeline register.
// PARAMETERS
//  LU_BUBBLES  1   bubbles inserted per load-use hazard (1..3; matches dmem read latency)
//  CNT_W       32  width of performance counters
// PORTS
//  clk           in   1      core clock, rising edge
//  rst_n         in   1      async active-low reset
//  id_rs1        in   5      rs1 of instruction in ID
//  id_rs2        in   5      rs2 of instruction in ID
//  id_rs1_used   in   1      ID instruction reads rs1
//  id_rs2_used   in   1      ID instruction reads rs2
//  ex_rs1        in   5      rs1 of instruction in EX (forwarding compare)
//  ex_rs2        in   5      rs2 of instruction in EX
//  ex_rd         in   5      rd of instruction in EX
//  ex_mem_read   in   1      EX instruction is a LOAD
//  ex_redirect   in   1      taken branch, JAL or JALR resolved in EX
//  mem_rd        in   5      rd in MEM
//  mem_reg_write in   1      MEM instruction writes rd
//  wb_rd         in   5      rd in WB
//  wb_reg_write  in   1      WB instruction writes rd
//  dmem_req      in   1      MEM stage has an access outstanding
//  dmem_ready    in   1      data memory completes the access this cycle
//  cnt_clr       in   1      sync clear of both counters
//  pc_stall      out  1      hold PC
//  if_id_stall   out  1      hold IF/ID
//  if_id_flush   out  1      zero IF/ID (NOP)
//  id_ex_stall   out  1      hold ID/EX
//  id_ex_flush   out  1      insert bubble into ID/EX
//  ex_mem_stall  out  1      hold EX/MEM
//  mem_wb_flush  out  1      bubble into MEM/WB
//  fwd_a         out  2      EX op A select: 00 regfile, 10 MEM result, 01 WB result
//  fwd_b         out  2      EX op B select, same encoding
//  stall_cnt     out  CNT_W  cycles with pc_stall=1
//  flush_cnt     out  CNT_W  redirect events taken
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - state=RUN, bub_cnt=0, counters=0.
//   - All outputs forced 0 while rst_n=0.
//   - Reset mid-stall abandons the stall; first cycle after release is RUN.
//  Hazard terms (combinational)
//   - lu_haz = ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
//   - mwait  = dmem_req & ~dmem_ready.
//  FSM states: RUN, LU_STALL, MEM_WAIT.
//  Priority each cycle: mwait > ex_redirect > lu_haz.
//  RUN
//   - mwait: freeze outputs (see MEM_WAIT) this cycle; next state MEM_WAIT.
//   - else ex_redirect: if_id_flush=1, id_ex_flush=1; flush_cnt++; stay RUN.
//     A simultaneous lu_haz is ignored (the consumer is flushed).
//   - else lu_haz: pc_stall=1, if_id_stall=1, id_ex_flush=1; bub_cnt=LU_BUBBLES-1;
//     next = (LU_BUBBLES==1) ? RUN : LU_STALL.
//  LU_STALL
//   - Same three outputs each cycle; bub_cnt-- ; leave to RUN when bub_cnt==1 at the edge.
//   - mwait here takes priority: enter MEM_WAIT, keeping bub_cnt for resumption.
//  MEM_WAIT
//   - Freeze: pc_stall=if_id_stall=id_ex_stall=ex_mem_stall=1, mem_wb_flush=1.
//   - ex_redirect is not acted on while frozen; it is held by the frozen EX stage.
//   - Exit on dmem_ready=1 that cycle to RUN (bub_cnt==0) or LU_STALL (bub_cnt!=0).
//  Forwarding (combinational; independent of state)
//   - fwd_a=10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1.
//   - else fwd_a=01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1.
//   - else 00. MEM has priority over WB. fwd_b is identical using ex_rs2.
//  Counters
//   - Saturate at all-ones; no wrap.
//   - cnt_clr wins over an increment in the same cycle.
//  Latency
//   - Stall/flush outputs are combinational, in the same cycle as the cause.
//   - State and counters update at the next clock edge.
// TESTING
//  1 LW x5 in EX, ADD x6,x5,x1 in ID, LU_BUBBLES=1 -> one cycle pc_stall=if_id_stall=id_ex_flush=1, stall_cnt=1
//  2 LU_BUBBLES=3, same pair -> 3 consecutive stall cycles, then RUN; stall_cnt=3
//  3 lu_haz and ex_redirect in the same cycle -> if_id_flush=id_ex_flush=1, pc_stall=0, flush_cnt=1
//  4 dmem_req=1, ready low 4 cycles -> 5 freeze cycles incl. ready cycle; redirect raised mid-wait acted on after exit
//  5 mem_rd=wb_rd=ex_rs1=7, both writing -> fwd_a=10; with rd=0 -> fwd_a=00
//  6 rst_n low during LU_STALL -> outputs 0 immediately, RUN after release; counter at max stays at max

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for the RV32I 5-stage core (IF/ID/EX/MEM/WB).
//   Inserts load-use stalls, flushes on taken branches/jumps resolved in EX,
//   freezes the pipe while a data-memory access is outstanding, produces the
//   EX-stage operand forwarding selects and keeps saturating stall/flush
//   counters for performance debug.
//
// Parameters
//   LU_BUBBLES  bubbles inserted per load-use hazard (1..3)
//   CNT_W       width of the performance counters
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   id_rs1/id_rs2, *_used         source registers of the ID instruction
//   ex_rs1/ex_rs2                 source registers of the EX instruction
//   ex_rd, ex_mem_read            destination / LOAD flag of the EX instruction
//   ex_redirect                   taken branch / JAL / JALR resolved in EX
//   mem_rd, mem_reg_write         MEM-stage writer
//   wb_rd, wb_reg_write           WB-stage writer
//   dmem_req, dmem_ready          data-memory handshake of the MEM stage
//   cnt_clr                       synchronous clear of both counters
//   pc_stall .. mem_wb_flush      stall/flush enables of the pipeline registers
//   fwd_a, fwd_b                  EX operand select: 00 regfile, 10 MEM, 01 WB
//   stall_cnt                     cycles with pc_stall asserted
//   flush_cnt                     redirect events taken
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // The first bubble is issued from RUN, so the counter holds the remainder.
    localparam logic [1:0] BUB_INIT = 2'(LU_BUBBLES - 1);

    state_t     state, state_nxt;
    logic [1:0] bub_cnt, bub_nxt;

    logic lu_haz;
    logic mwait;

    logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c;
    logic id_ex_flush_c, ex_mem_stall_c, mem_wb_flush_c;
    logic flush_evt;

    logic [1:0] fwd_a_c, fwd_b_c;

    assign lu_haz = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

    assign mwait = dmem_req && !dmem_ready;

    always_comb begin
        state_nxt      = state;
        bub_nxt        = bub_cnt;
        flush_evt      = 1'b0;
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_stall_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_stall_c = 1'b0;
        mem_wb_flush_c = 1'b0;

        case (state)
            RUN: begin
                if (mwait) begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    id_ex_stall_c  = 1'b1;
                    ex_mem_stall_c = 1'b1;
                    mem_wb_flush_c = 1'b1;
                    state_nxt      = MEM_WAIT;
                end else if (ex_redirect) begin
                    // A load-use consumer in ID is flushed anyway, so no stall.
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    flush_evt     = 1'b1;
                end else if (lu_haz) begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    bub_nxt       = BUB_INIT;
                    state_nxt     = (LU_BUBBLES == 1) ? RUN : LU_STALL;
                end
            end

            LU_STALL: begin
                if (mwait) begin
                    // Remaining bubbles are kept and resumed after the wait.
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    id_ex_stall_c  = 1'b1;
                    ex_mem_stall_c = 1'b1;
                    mem_wb_flush_c = 1'b1;
                    state_nxt      = MEM_WAIT;
                end else begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    bub_nxt       = 2'(bub_cnt - 2'd1);
                    if (bub_cnt == 2'd1) begin
                        state_nxt = RUN;
                    end
                end
            end

            MEM_WAIT: begin
                // The ready cycle is still frozen; a redirect stays parked in EX.
                pc_stall_c     = 1'b1;
                if_id_stall_c  = 1'b1;
                id_ex_stall_c  = 1'b1;
                ex_mem_stall_c = 1'b1;
                mem_wb_flush_c = 1'b1;
                if (dmem_ready) begin
                    state_nxt = (bub_cnt == 2'd0) ? RUN : LU_STALL;
                end
            end

            default: begin
                state_nxt = RUN;
                bub_nxt   = 2'd0;
            end
        endcase
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            return 2'b10;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign fwd_a_c = fwd_sel(ex_rs1);
    assign fwd_b_c = fwd_sel(ex_rs2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            bub_cnt   <= 2'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bub_cnt <= bub_nxt;

            if (cnt_clr) begin
                stall_cnt <= '0;
            end else if (pc_stall_c && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            if (cnt_clr) begin
                flush_cnt <= '0;
            end else if (flush_evt && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    // Every output is held low while reset is asserted, independent of inputs.
    assign pc_stall     = rst_n & pc_stall_c;
    assign if_id_stall  = rst_n & if_id_stall_c;
    assign if_id_flush  = rst_n & if_id_flush_c;
    assign id_ex_stall  = rst_n & id_ex_stall_c;
    assign id_ex_flush  = rst_n & id_ex_flush_c;
    assign ex_mem_stall = rst_n & ex_mem_stall_c;
    assign mem_wb_flush = rst_n & mem_wb_flush_c;
    assign fwd_a        = rst_n ? fwd_a_c : 2'b00;
    assign fwd_b        = rst_n ? fwd_b_c : 2'b00;

endmodule
